// File: rtl/dcache_tbus_responder_pkg.sv
// Shared types for the D-cache tbus responder: line geometry, the tbus
// (cache side) and cbus (memory side) request/response structs, the cbus
// size/length encodings and the responder state enum.
`timescale 1ns/1ps

package dcache_tbus_responder_pkg;

   // Words per cache line and byte-offset bits within a line.
   localparam int Dcacheline_len     = 16;
   localparam int DCACHE_OFFSET_BITS = 6;
   localparam int ADDR_W             = 32;
   localparam int WORD_W             = 32;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [WORD_W-1:0] word_t;
   typedef logic [3:0]        strb_t;
   typedef word_t [Dcacheline_len-1:0] line_t;

   // Bytes per beat on cbus.
   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2
   } msize_t;

   // Burst length on cbus, encoded as beats minus one.
   typedef enum logic [3:0] {
      MLEN1  = 4'd0,
      MLEN2  = 4'd1,
      MLEN4  = 4'd3,
      MLEN8  = 4'd7,
      MLEN16 = 4'd15
   } mlen_t;

   typedef struct packed {
      logic   valid;
      logic   is_write;
      msize_t size;
      addr_t  addr;
      strb_t  strobe;
      line_t  data;
      logic   is_uncached;
   } tbus_req_t;

   typedef struct packed {
      logic  data_ok;
      line_t data;
   } tbus_resp_t;

   typedef struct packed {
      logic   valid;
      logic   is_write;
      msize_t size;
      addr_t  addr;
      strb_t  strobe;
      word_t  data;
      mlen_t  len;
   } cbus_req_t;

   typedef struct packed {
      logic  ready;
      logic  last;
      word_t data;
   } cbus_resp_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RBURST = 2'd1,
      WBURST = 2'd2,
      RESP   = 2'd3
   } resp_state_t;

endpackage

// File: rtl/dcache_tbus_responder.sv
// Responder end of the D-cache tbus. Each accepted request (line read,
// line writeback or uncached single access) is replayed as a word-wide
// burst on cbus; completion goes back to the cache as a one-cycle data_ok,
// carrying the whole line for line reads.
`timescale 1ns/1ps

module dcache_tbus_responder
   import dcache_tbus_responder_pkg::*;
#(
   parameter int LINE_WORDS  = Dcacheline_len,
   parameter int OFFSET_BITS = DCACHE_OFFSET_BITS
) (
   input  logic       clk,
   input  logic       reset,
   input  tbus_req_t  treq,
   output tbus_resp_t tresp,
   output cbus_req_t  creq,
   input  cbus_resp_t cresp
);

   localparam int                   BEAT_BITS   = $clog2(LINE_WORDS);
   localparam logic [BEAT_BITS-1:0] BEAT_MAX    = BEAT_BITS'(LINE_WORDS - 1);
   localparam addr_t                OFFSET_MASK = addr_t'((1 << OFFSET_BITS) - 1);

   resp_state_t          state;
   resp_state_t          state_next;
   logic [BEAT_BITS-1:0] beat;
   logic [BEAT_BITS-1:0] beat_inc;
   line_t                line_buf;

   // Request fields captured at acceptance; cbus is driven only from these
   // so treq never reaches creq combinationally.
   addr_t                req_addr;
   msize_t               req_size;
   strb_t                req_strobe;
   mlen_t                req_len;
   logic                 req_write;
   logic                 req_uncached;

   // Beat counter sticks at the last word so extra beats just land on it.
   assign beat_inc = (beat == BEAT_MAX) ? beat : beat + BEAT_BITS'(1);

   // State register; reset abandons any burst in flight without a data_ok.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: bursts end only on a ready&last handshake, and RESP
   // always falls back to IDLE so a new request is taken one cycle later.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (treq.valid) begin
               state_next = treq.is_write ? WBURST : RBURST;
            end
         end
         RBURST, WBURST: begin
            if (cresp.ready && cresp.last) begin
               state_next = RESP;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Request latch, beat counter and line buffer: lines are aligned and sent
   // as full-word 16-beat bursts, uncached accesses pass through unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         beat         <= '0;
         line_buf     <= '0;
         req_addr     <= '0;
         req_size     <= MSIZE1;
         req_strobe   <= '0;
         req_len      <= MLEN1;
         req_write    <= 1'b0;
         req_uncached <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (treq.valid) begin
                  beat         <= '0;
                  req_write    <= treq.is_write;
                  req_uncached <= treq.is_uncached;
                  if (treq.is_uncached) begin
                     req_addr   <= treq.addr;
                     req_size   <= treq.size;
                     req_strobe <= treq.strobe;
                     req_len    <= MLEN1;
                  end else begin
                     req_addr   <= treq.addr & ~OFFSET_MASK;
                     req_size   <= MSIZE4;
                     req_strobe <= 4'b1111;
                     req_len    <= MLEN16;
                  end
                  if (treq.is_write) begin
                     line_buf <= treq.data;
                  end
               end
            end
            RBURST: begin
               if (cresp.ready) begin
                  line_buf[beat] <= cresp.data;
                  beat           <= beat_inc;
               end
            end
            WBURST: begin
               if (cresp.ready) begin
                  beat <= beat_inc;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // cbus request decode: valid follows the burst states, every other field
   // comes from the latched request and the line buffer.
   always_comb begin
      creq          = '0;
      creq.valid    = (state == RBURST) || (state == WBURST);
      creq.is_write = req_write;
      creq.size     = req_size;
      creq.addr     = req_addr;
      creq.strobe   = req_strobe;
      creq.len      = req_len;
      if (req_write) begin
         creq.data = line_buf[beat];
      end
   end

   // tbus response: data is only meaningful alongside data_ok and is zero
   // for writes; uncached reads return just the captured word 0.
   always_comb begin
      tresp = '0;
      if (state == RESP) begin
         tresp.data_ok = 1'b1;
         if (!req_write) begin
            if (req_uncached) begin
               tresp.data[0] = line_buf[0];
            end else begin
               tresp.data = line_buf;
            end
         end
      end
   end

endmodule

// File: tb/tb_dcache_tbus_responder.sv
// Directed testbench for dcache_tbus_responder: a cache-side requester and a
// scripted cbus memory, with hand-computed expected values for each case.
`timescale 1ns/1ps

module tb_dcache_tbus_responder;
   import dcache_tbus_responder_pkg::*;

   logic       clk;
   logic       reset;
   tbus_req_t  treq;
   tbus_resp_t tresp;
   cbus_req_t  creq;
   cbus_resp_t cresp;

   int testsRun;
   int testsFailed;

   // Results of the most recent transaction, filled in by runTransaction.
   int         okCycle;
   int         okCount;
   int         burstStart;
   int         lastHsCycle;
   bit         txDone;
   line_t      okData;
   cbus_req_t  firstReq;
   word_t      hsData[$];
   strb_t      hsStrobe[$];

   dcache_tbus_responder #(
      .LINE_WORDS (16),
      .OFFSET_BITS(6)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .treq (treq),
      .tresp(tresp),
      .creq (creq),
      .cresp(cresp)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something upstream hangs.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Builds a tbus request; line writes carry dataBase+i, uncached ones only word 0.
   function automatic tbus_req_t makeReq(input bit isWrite, input bit uncached, input addr_t addr,
                                         input msize_t size, input strb_t strobe, input word_t dataBase);
      tbus_req_t r;
      r             = '0;
      r.valid       = 1'b1;
      r.is_write    = isWrite;
      r.is_uncached = uncached;
      r.addr        = addr;
      r.size        = size;
      r.strobe      = strobe;
      if (uncached) begin
         r.data[0] = dataBase;
      end else begin
         for (int i = 0; i < 16; i++) r.data[i] = dataBase + word_t'(i);
      end
      return r;
   endfunction

   // Drives one request from cycle 0 and plays memory: beat n returns
   // dataBase+n, last on beat lastBeat. Returns in the cycle after data_ok
   // with treq set to nextReq. Cycle numbers are relative to the call.
   task automatic applyStimulus(input string tag, input tbus_req_t req, input tbus_req_t nextReq,
                                input word_t dataBase, input int lastBeat, input bit toggleReady,
                                input int budget);
      int  n;
      int  c;
      bit  phase;
      treq        = req;
      cresp       = '0;
      n           = 0;
      c           = 0;
      phase       = 1'b1;
      okCycle     = -1;
      okCount     = 0;
      burstStart  = -1;
      lastHsCycle = -1;
      txDone      = 1'b0;
      okData      = '0;
      firstReq    = '0;
      hsData.delete();
      hsStrobe.delete();
      while (!txDone && c < budget) begin
         @(posedge clk);
         #1;
         c++;
         if (tresp.data_ok) begin
            okCount++;
            if (okCycle < 0) begin
               okCycle = c;
               okData  = tresp.data;
            end
         end
         cresp = '0;
         if (okCycle >= 0 && c > okCycle) begin
            treq   = nextReq;
            txDone = 1'b1;
         end else if (creq.valid) begin
            if (burstStart < 0) begin
               burstStart = c;
               firstReq   = creq;
            end
            cresp.ready = toggleReady ? phase : 1'b1;
            phase       = ~phase;
            cresp.data  = dataBase + word_t'(n);
            cresp.last  = (n == lastBeat);
            if (cresp.ready) begin
               hsData.push_back(creq.data);
               hsStrobe.push_back(creq.strobe);
               if (cresp.last) lastHsCycle = c;
               n++;
            end
         end
      end
      checkOutput({tag, "_completed"}, 32'(txDone), 32'd1);
   endtask

   tbus_req_t idleReq;
   tbus_req_t reqA;
   tbus_req_t reqB;
   int        abortBeats;
   int        abortOk;

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      idleReq     = '0;
      treq        = '0;
      cresp       = '0;
      reset       = 1'b1;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_creq_valid", 32'(creq.valid), 32'd0);
      checkOutput("rst_creq_addr", creq.addr, 32'd0);
      checkOutput("rst_creq_len", 32'(creq.len), 32'd0);
      checkOutput("rst_data_ok", 32'(tresp.data_ok), 32'd0);
      checkOutput("rst_tresp_w0", tresp.data[0], 32'd0);
      reset = 1'b0;

      // Line read, ready held high: addr aligned, data_ok at cycle 17.
      applyStimulus("rd", makeReq(1'b0, 1'b0, 32'h8000_1234, MSIZE4, 4'h0, 32'h0),
                    idleReq, 32'h100, 15, 1'b0, 40);
      checkOutput("rd_addr", firstReq.addr, 32'h8000_1200);
      checkOutput("rd_len", 32'(firstReq.len), 32'(MLEN16));
      checkOutput("rd_size", 32'(firstReq.size), 32'(MSIZE4));
      checkOutput("rd_is_write", 32'(firstReq.is_write), 32'd0);
      checkOutput("rd_burst_start", 32'(burstStart), 32'd1);
      checkOutput("rd_ok_cycle", 32'(okCycle), 32'd17);
      checkOutput("rd_ok_width", 32'(okCount), 32'd1);
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("rd_word%0d", i), okData[i], 32'h100 + 32'(i));
      end

      // Early last on beat 3: words 0..3 new, 4..15 keep the previous line.
      applyStimulus("early", makeReq(1'b0, 1'b0, 32'h8000_3000, MSIZE4, 4'h0, 32'h0),
                    idleReq, 32'h200, 3, 1'b0, 40);
      checkOutput("early_ok_cycle", 32'(okCycle), 32'd5);
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("early_word%0d", i), okData[i],
                     (i < 4) ? 32'h200 + 32'(i) : 32'h100 + 32'(i));
      end

      // Line write with ready toggling: beats at odd cycles, last at 31.
      applyStimulus("wr", makeReq(1'b1, 1'b0, 32'h8000_2240, MSIZE4, 4'h0, 32'hA0),
                    idleReq, 32'h0, 15, 1'b1, 80);
      checkOutput("wr_addr", firstReq.addr, 32'h8000_2240);
      checkOutput("wr_is_write", 32'(firstReq.is_write), 32'd1);
      checkOutput("wr_beats", 32'(hsData.size()), 32'd16);
      for (int i = 0; i < hsData.size(); i++) begin
         checkOutput($sformatf("wr_beat%0d", i), hsData[i], 32'hA0 + 32'(i));
         checkOutput($sformatf("wr_strb%0d", i), 32'(hsStrobe[i]), 32'hF);
      end
      checkOutput("wr_last_cycle", 32'(lastHsCycle), 32'd31);
      checkOutput("wr_ok_cycle", 32'(okCycle), 32'd32);
      checkOutput("wr_ok_width", 32'(okCount), 32'd1);
      checkOutput("wr_resp_zero", 32'(okData != '0), 32'd0);

      // Uncached byte read: address/size pass through, one beat.
      applyStimulus("ucrd", makeReq(1'b0, 1'b1, 32'h1FD0_0004, MSIZE1, 4'b0001, 32'h0),
                    idleReq, 32'h55, 0, 1'b0, 20);
      checkOutput("ucrd_addr", firstReq.addr, 32'h1FD0_0004);
      checkOutput("ucrd_len", 32'(firstReq.len), 32'(MLEN1));
      checkOutput("ucrd_size", 32'(firstReq.size), 32'(MSIZE1));
      checkOutput("ucrd_strobe", 32'(firstReq.strobe), 32'h1);
      checkOutput("ucrd_ok_cycle", 32'(okCycle), 32'd2);
      checkOutput("ucrd_word0", okData[0], 32'h55);
      checkOutput("ucrd_upper_zero", 32'(okData[15:1] != '0), 32'd0);

      // Back-to-back: writeback A, then read B presented right after data_ok.
      reqA = makeReq(1'b1, 1'b0, 32'h8000_4000, MSIZE4, 4'h0, 32'hC0);
      reqB = makeReq(1'b0, 1'b0, 32'h8000_5010, MSIZE4, 4'h0, 32'h0);
      applyStimulus("b2bA", reqA, reqB, 32'h0, 15, 1'b0, 40);
      checkOutput("b2bA_beats", 32'(hsData.size()), 32'd16);
      checkOutput("b2bA_ok_cycle", 32'(okCycle), 32'd17);
      applyStimulus("b2bB", reqB, idleReq, 32'h300, 15, 1'b0, 40);
      checkOutput("b2bB_burst_start", 32'(burstStart), 32'd1);
      checkOutput("b2bB_addr", firstReq.addr, 32'h8000_5000);
      checkOutput("b2bB_is_write", 32'(firstReq.is_write), 32'd0);
      checkOutput("b2bB_beats", 32'(hsData.size()), 32'd16);
      checkOutput("b2bB_ok_cycle", 32'(okCycle), 32'd17);
      checkOutput("b2bB_word5", okData[5], 32'h305);

      // Reset at beat 7 of a line read: burst dropped, no data_ok.
      treq       = makeReq(1'b0, 1'b0, 32'h8000_6000, MSIZE4, 4'h0, 32'h0);
      cresp      = '0;
      abortBeats = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         cresp = '0;
         if (creq.valid) begin
            if (abortBeats == 7) break;
            cresp.ready = 1'b1;
            cresp.data  = 32'h400 + 32'(abortBeats);
            abortBeats++;
         end
      end
      checkOutput("abort_reached_beat7", 32'(abortBeats), 32'd7);
      reset = 1'b1;
      treq  = '0;
      cresp = '0;
      @(posedge clk);
      #1;
      checkOutput("abort_valid_after_rst", 32'(creq.valid), 32'd0);
      reset   = 1'b0;
      abortOk = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         if (tresp.data_ok) abortOk++;
      end
      checkOutput("abort_no_data_ok", 32'(abortOk), 32'd0);

      // Uncached word write after the abort completes normally.
      applyStimulus("ucwr", makeReq(1'b1, 1'b1, 32'h1FD0_0010, MSIZE4, 4'b1100, 32'hDEAD_BEEF),
                    idleReq, 32'h0, 0, 1'b0, 20);
      checkOutput("ucwr_addr", firstReq.addr, 32'h1FD0_0010);
      checkOutput("ucwr_len", 32'(firstReq.len), 32'(MLEN1));
      checkOutput("ucwr_beats", 32'(hsData.size()), 32'd1);
      if (hsData.size() > 0) begin
         checkOutput("ucwr_data", hsData[0], 32'hDEAD_BEEF);
         checkOutput("ucwr_strobe", 32'(hsStrobe[0]), 32'hC);
      end
      checkOutput("ucwr_ok_cycle", 32'(okCycle), 32'd2);
      checkOutput("ucwr_resp_zero", okData[0], 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/dcache_tbus_responder.md
Name: dcache_tbus_responder

Overview:
- Responder (slave) end of the tbus interface driven by the data cache.
- Accepts a full-line read, a full-line writeback, or an uncached single access on tbus.
- Runs each request as a word-wide burst on the cbus memory port.
- Returns completion as a single-cycle data_ok, with the whole line for line reads.
- Sits between the D-cache and the memory/AXI crossbar.

Parameters:
- LINE_WORDS, 16, words per cache line; must equal Dcacheline_len.
- OFFSET_BITS, 6, byte-offset bits per line; equals log2(LINE_WORDS*4).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset.
- treq  in  tbus_req_t  request from cache: valid, is_write, size, addr, strobe, data[LINE_WORDS], is_uncached.
- tresp  out  tbus_resp_t  response to cache: data_ok, data[LINE_WORDS].
- creq  out  cbus_req_t  memory request: valid, is_write, size, addr, strobe, data, len.
- cresp  in  cbus_resp_t  memory response: ready, last, data.

Interface decision: one clock (clk); reset is synchronous and active-high, named reset.

Behaviour:
- tbus rules:
  - The requester holds treq stable while valid, until it sees data_ok.
  - data_ok is a one-cycle pulse.
  - In the cycle after data_ok, treq may carry a new request or be deasserted.
- Request classes, latched in IDLE:
  - Line read: is_uncached=0, is_write=0. addr is forced line-aligned (low OFFSET_BITS zeroed). cbus burst uses size MSIZE4 and len = LINE_WORDS beats (MLEN16).
  - Line write: is_uncached=0, is_write=1. Same alignment and burst shape. Every beat has strobe 4'b1111; data comes from the latched line, word index = beat.
  - Uncached: is_uncached=1. One beat (MLEN1) using treq's addr, size, strobe and data[0] unchanged.
- FSM states: IDLE, RBURST, WBURST, RESP.
- IDLE:
  - creq.valid=0, tresp.data_ok=0.
  - If treq.valid: latch addr, size, strobe, is_write, is_uncached and (for writes) the line into line_buf; clear beat to 0.
  - Next state is RBURST or WBURST.
- RBURST:
  - creq.valid=1, creq fields driven from latched registers only.
  - On cresp.ready: line_buf[beat] <= cresp.data; beat increments.
  - On ready && last: go to RESP.
- WBURST:
  - creq.valid=1, creq.data=line_buf[beat].
  - On ready: beat increments.
  - On ready && last: go to RESP.
- RESP:
  - tresp.data_ok=1 for exactly one cycle, then IDLE.
  - A new treq.valid seen in RESP is NOT latched; it is accepted in the following IDLE cycle.
- tresp.data:
  - Line read: line_buf.
  - Uncached read: word 0 = captured beat, words 1..LINE_WORDS-1 = 0.
  - Any write: all zero.
  - tresp.data is valid only while data_ok is high.
- beat counter:
  - Width log2(LINE_WORDS); saturates at LINE_WORDS-1.
  - Early last: completes the burst, unfilled words keep stale values.
  - Extra beats after saturation overwrite or repeat the final word.
  - Completion is decided by last only.
- creq fields are registered, so there are no combinational paths from treq to creq.
- Latency:
  - Line read with cresp.ready held high: accept at cycle 0, creq.valid from cycle 1, last at cycle 16, data_ok at cycle 17.
  - Uncached access: data_ok at cycle 2 minimum.
- Reset values:
  - State IDLE, beat 0, line_buf 0.
  - creq all 0 (valid=0).
  - tresp.data_ok=0, tresp.data=0.
- Reset mid-burst:
  - FSM returns to IDLE.
  - creq.valid is 0 from the next cycle.
  - No data_ok is issued for the aborted request.
- cresp.ready while in IDLE or RESP is ignored.

Decomposition:
- Shared package (common.svh):
  - LINE_WORDS / Dcacheline_len constant.
  - line_t typedef (word_t[LINE_WORDS-1:0]).
  - tbus_req_t, tbus_resp_t, cbus_req_t, cbus_resp_t.
  - MSIZE*/MLEN* enums.
  - Responder state enum (IDLE, RBURST, WBURST, RESP).
- No sub-module: the line buffer is a plain register array in this block.

Test Plan:
- Line read, addr 0x8000_1234, cresp.ready=1 and data=0x100+beat, last on beat 15 -> creq.addr=0x8000_1200, len MLEN16; data_ok at cycle 17 with data[i]=0x100+i; data_ok high exactly 1 cycle.
- Line write, addr 0x8000_2240, data[i]=0xA0+i, ready toggling 1/0 -> beats carry 0xA0..0xAF in order, strobe 4'b1111 each beat; data_ok one cycle after last handshake; tresp.data all 0.
- Uncached read, addr 0x1FD0_0004, size MSIZE1, cresp.data=0x55 -> creq addr unaligned as given, len MLEN1, size MSIZE1; tresp.data[0]=0x55, others 0.
- Back-to-back: writeback of line A, treq switching to read of line B in the cycle after data_ok -> B accepted exactly once, no duplicate A burst; B's burst begins 2 cycles after A's data_ok.
- reset asserted at beat 7 of a line read, then a new uncached write -> creq.valid=0 the cycle after reset, no data_ok for the aborted read; the new request completes normally.
- Early last on beat 3 of a line read -> data_ok the next cycle; words 0..3 updated, words 4..15 retain their prior values.
